operand_loader: RTL
===================

OPERAND_LOADER -- requirements
Module: operand_loader

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; SW width is 2*WIDTH.
REQ-002 Parameter DB_CYCLES, default 4, consecutive high samples of BTN_LOAD needed for one press event (range 1..2^16-1).
REQ-003 Parameter TIMEOUT, default 64, maximum cycles spent in S_WAIT before abort (range 1..2^16-1).
REQ-004 CLK  input  1  single system clock; all state updates on rising edge.
REQ-005 RST  input  1  asynchronous, active-high reset.
REQ-006 SW  input  2*WIDTH  switch bus, already synchronized upstream.
REQ-007 BTN_LOAD  input  1  load button level, already synchronized upstream.
REQ-008 MULT_DONE  input  1  multiplier completion pulse/level.
REQ-009 OP_A  output  WIDTH  captured multiplicand, registered.
REQ-010 OP_B  output  WIDTH  captured multiplier, registered.
REQ-011 MULT_START  output  1  one-cycle start pulse to multiplier, registered.
REQ-012 BUSY  output  1  high while in S_RUN or S_WAIT.
REQ-013 ERR  output  1  sticky timeout flag.
REQ-014 STATE  output  2  current FSM encoding for LEDs.

Function
REQ-015 Debounce counter SHALL increment while BTN_LOAD=1, saturate at DB_CYCLES, and clear to 0 in any cycle BTN_LOAD=0.
REQ-016 Press event SHALL be asserted for exactly one cycle: the cycle the counter value equals DB_CYCLES-1 and BTN_LOAD=1 (transition to DB_CYCLES); holding the button yields no further events until BTN_LOAD returns to 0.
REQ-017 FSM states and encodings SHALL be S_A=00, S_B=01, S_RUN=10, S_WAIT=11.
REQ-018 S_A: on press event, OP_A <= SW[WIDTH-1:0], ERR <= 0, next S_B; otherwise hold.
REQ-019 S_B: on press event, OP_B <= SW[2*WIDTH-1:WIDTH], next S_RUN; otherwise hold.
REQ-020 S_RUN: MULT_START=1 for this single cycle, timeout counter <= 0, next S_WAIT unconditionally.
REQ-021 S_WAIT: MULT_DONE=1 -> next S_A; else timeout counter increments; when it reaches TIMEOUT-1 without MULT_DONE -> ERR <= 1, next S_A.
REQ-022 MULT_DONE and timeout expiry in the same cycle SHALL count as success (ERR unchanged).
REQ-023 Press events in S_RUN or S_WAIT SHALL be discarded, not queued.
REQ-024 MULT_DONE outside S_WAIT SHALL be ignored.
REQ-025 OP_A and OP_B SHALL remain stable from capture until the next capture in S_A/S_B respectively.
REQ-026 Latency: press event in cycle N -> operand and STATE updated after edge N; MULT_START high in cycle after OP_B capture.
REQ-027 BUSY SHALL equal STATE[1].

Reset
REQ-028 RST=1 SHALL immediately, without clock, force STATE=S_A, OP_A=0, OP_B=0, MULT_START=0, BUSY=0, ERR=0, debounce and timeout counters=0.
REQ-029 RST asserted mid-operation (any state) SHALL abort it; no MULT_START pulse may follow reset release without two fresh press events.
REQ-030 After RST release with BTN_LOAD already high, a press event SHALL require DB_CYCLES new consecutive high samples.

Verification (DB_CYCLES=4, TIMEOUT=8, WIDTH=8)
REQ-031 SW=16'h0503, BTN high 4 cycles, low, SW=16'h0700, BTN high 4 cycles -> OP_A=8'h03, OP_B=8'h07, one MULT_START pulse, STATE 00->01->10->11.
REQ-032 BTN high 3 cycles then low, repeated 5 times -> no press event, STATE stays 00, OP_A=0.
REQ-033 BTN held high 20 cycles in S_A -> exactly one capture, STATE=01.
REQ-034 In S_WAIT, no MULT_DONE for 8 cycles -> ERR=1, STATE=00; next press in S_A clears ERR.
REQ-035 In S_WAIT, MULT_DONE on the expiry cycle -> STATE=00, ERR=0; presses during S_WAIT produce no capture.
REQ-036 RST pulse (asynchronous, mid-cycle) while STATE=11 -> all outputs 0 immediately, STATE=00, no MULT_START afterwards.

Source files
------------

// File: rtl/operand_loader.sv
// Two-press operand loader: debounces BTN_LOAD, captures OP_A then OP_B from SW,
// pulses MULT_START and waits (with timeout) for the multiplier to finish.
module operand_loader #(
    parameter int WIDTH     = 8,
    parameter int DB_CYCLES = 4,
    parameter int TIMEOUT   = 64
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [2*WIDTH-1:0] SW,
    input  logic               BTN_LOAD,
    input  logic               MULT_DONE,
    output logic [WIDTH-1:0]   OP_A,
    output logic [WIDTH-1:0]   OP_B,
    output logic               MULT_START,
    output logic               BUSY,
    output logic               ERR,
    output logic [1:0]         STATE
);

    typedef enum logic [1:0] {
        S_A    = 2'b00,
        S_B    = 2'b01,
        S_RUN  = 2'b10,
        S_WAIT = 2'b11
    } state_t;

    localparam logic [15:0] DB_MAX  = 16'(DB_CYCLES);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_t          state, state_next;
    logic [15:0]     db_cnt;
    logic [15:0]     to_cnt, to_next;
    logic [WIDTH-1:0] op_a_next, op_b_next;
    logic            start_next, err_next;
    logic            press;

    // The event fires only on the count's transition into saturation, so a held
    // button produces a single press until it is released.
    assign press = BTN_LOAD && (db_cnt == DB_MAX - 16'd1);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            db_cnt <= '0;
        end else if (!BTN_LOAD) begin
            db_cnt <= '0;
        end else if (db_cnt != DB_MAX) begin
            db_cnt <= db_cnt + 16'd1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= S_A;
            to_cnt     <= '0;
            OP_A       <= '0;
            OP_B       <= '0;
            MULT_START <= 1'b0;
            ERR        <= 1'b0;
        end else begin
            state      <= state_next;
            to_cnt     <= to_next;
            OP_A       <= op_a_next;
            OP_B       <= op_b_next;
            MULT_START <= start_next;
            ERR        <= err_next;
        end
    end

    // NOTE: every output of this block is defaulted first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_next = state;
        to_next    = to_cnt;
        op_a_next  = OP_A;
        op_b_next  = OP_B;
        start_next = 1'b0;
        err_next   = ERR;
        unique case (state)
            S_A: begin
                if (press) begin
                    op_a_next  = SW[WIDTH-1:0];
                    err_next   = 1'b0;
                    state_next = S_B;
                end
            end
            S_B: begin
                if (press) begin
                    op_b_next  = SW[2*WIDTH-1:WIDTH];
                    start_next = 1'b1;
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                to_next    = '0;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                // Completion wins over a coincident timeout expiry.
                if (MULT_DONE) begin
                    state_next = S_A;
                end else if (to_cnt == TO_LAST) begin
                    err_next   = 1'b1;
                    state_next = S_A;
                end else begin
                    to_next = to_cnt + 16'd1;
                end
            end
            default: state_next = S_A;
        endcase
    end

    assign STATE = state;
    assign BUSY  = state[1];

endmodule
